// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// MIPS_LOGIC_IMM_EN adds the LOGIEX state for andi/ori.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BREX, ADDIEX, IMMWB, JEX
`ifdef MIPS_LOGIC_IMM_EN
    , LOGIEX
`endif
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGI  = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps aluop/funct/op onto the ALU operation code.
module mips_aludec
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          aluop,
  input  logic [5:0]          funct,
  input  logic [5:0]          op,
  output logic [ALUCTL_W-1:0] alucontrol
);

  logic [2:0] ctl;

  always_comb begin
    ctl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct codes fall back to add without flagging.
        case (funct)
          F_ADD:   ctl = ALU_ADD;
          F_SUB:   ctl = ALU_SUB;
          F_AND:   ctl = ALU_AND;
          F_OR:    ctl = ALU_OR;
          F_SLT:   ctl = ALU_SLT;
          default: ctl = ALU_ADD;
        endcase
      end
      default: begin
        case (op)
          OP_ANDI: ctl = ALU_AND;
          OP_ORI:  ctl = ALU_OR;
          default: ctl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign alucontrol = ALUCTL_W'(ctl);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// MIPS_LOGIC_IMM_EN enables andi/ori through the LOGIEX state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTL_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic                iord,
  output logic                regdst,
  output logic                memtoreg,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                immsel,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal_op
);

  statetype   state_q, state_d;
  logic       mem_rdy;
  logic       pcwrite, branch, mem_wr, ir_wr, reg_wr;
  logic [1:0] aluop;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    immsel     = 1'b0;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        ir_wr   = mem_rdy;
        pcwrite = mem_rdy;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = RTYPEEX;
          OP_BEQ, OP_BNE: state_d = BREX;
          OP_ADDI:        state_d = ADDIEX;
          OP_J:           state_d = JEX;
`ifdef MIPS_LOGIC_IMM_EN
          OP_ANDI, OP_ORI: state_d = LOGIEX;
`endif
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        reg_wr   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_rdy) state_d = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst  = 1'b1;
        reg_wr  = 1'b1;
        state_d = FETCH;
      end
      BREX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
      end
      IMMWB: begin
        reg_wr  = 1'b1;
`ifdef MIPS_LOGIC_IMM_EN
        immsel  = 1'b1;
`endif
        state_d = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
`ifdef MIPS_LOGIC_IMM_EN
      LOGIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_LOGI;
        immsel  = 1'b1;
        state_d = IMMWB;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Write enables are squashed combinationally so reset cannot commit a partial write.
  assign pcen     = (pcwrite | (branch & (op == OP_BEQ) & zero)
                             | (branch & (op == OP_BNE) & ~zero)) & ~reset;
  assign memwrite = mem_wr & ~reset;
  assign irwrite  = ir_wr & ~reset;
  assign regwrite = reg_wr & ~reset;

  mips_aludec #(.ALUCTL_W(ALUCTL_W)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .op         (op),
    .alucontrol (alucontrol)
  );

endmodule
